// File: rtl/alu_op_dispatcher_if.sv
// alu_op_dispatcher_if
// Groups the command and response handshake bundles of the ALU op dispatcher.
//
// Signals:
//   cmd_valid / cmd_ready          command handshake (sequencer -> dispatcher)
//   cmd_opcode, cmd_a, cmd_b,      command payload: ALU opcode, operands,
//   cmd_shift, cmd_tag             rotate amount and a tag returned with the result
//   rsp_valid / rsp_ready          response handshake (dispatcher -> consumer)
//   rsp_result, rsp_flags,         response payload: result, {carry, zero, sign},
//   rsp_tag, rsp_err               tag, and the illegal-opcode marker
//
// Modports:
//   master  sequencer/consumer side (drives commands, accepts responses)
//   slave   dispatcher side
interface alu_op_dispatcher_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_opcode;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [4:0]       cmd_shift;
   logic [TAG_W-1:0] cmd_tag;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic [2:0]       rsp_flags;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_err;

   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag, rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err
   );

endinterface

// File: rtl/alu_op_dispatcher.sv
// alu_op_dispatcher
// Issue stage in front of the pipelined ALU. Tagged commands are buffered in a
// command FIFO and issued one per cycle onto registered ALU operand/opcode
// ports. The ALU has no valid output, so a valid/tag delay line follows each
// operation through the ALU latency; when it emerges, the ALU result and flags
// are captured into a response FIFO. Issue is credit-limited (in flight plus
// queued responses never exceed RSP_DEPTH), so a captured result is never lost.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   bus (slave)         command handshake in, response handshake out
//   alu_opcode,         registered ALU opcode / operands / rotate amount
//   alu_input1/2,
//   alu_shiftValue
//   alu_result,         ALU result register and its flags
//   alu_carry/zero/sign
//   busy                any command queued, in flight or awaiting pop
//
// Optional feature: define ALU_DISP_OPCHECK_EN to flag opcodes above 7 with
// rsp_err = 1 (they are still issued). Without it rsp_err is tied to 0.
module alu_op_dispatcher #(
   parameter int WIDTH     = 32,
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int ALU_LAT   = 2,
   parameter int TAG_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   alu_op_dispatcher_if.slave bus,
   output logic [3:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_input1,
   output logic [WIDTH-1:0] alu_input2,
   output logic [4:0]       alu_shiftValue,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   input  logic             alu_zero,
   input  logic             alu_sign,
   output logic             busy
);

   localparam int CA = $clog2(CMD_DEPTH);
   localparam int RA = $clog2(RSP_DEPTH);
   localparam int DL = ALU_LAT + 1;
   localparam logic [RA:0] RSP_DEPTH_C = (RA+1)'(RSP_DEPTH);

   // Command FIFO storage and pointers (extra MSB is the wrap bit)
   logic [3:0]       cmd_op_mem  [CMD_DEPTH];
   logic [WIDTH-1:0] cmd_a_mem   [CMD_DEPTH];
   logic [WIDTH-1:0] cmd_b_mem   [CMD_DEPTH];
   logic [4:0]       cmd_sh_mem  [CMD_DEPTH];
   logic [TAG_W-1:0] cmd_tag_mem [CMD_DEPTH];
   logic [CA:0]      cmd_wr_ptr;
   logic [CA:0]      cmd_rd_ptr;
   logic [CA-1:0]    cmd_wr_idx;
   logic [CA-1:0]    cmd_rd_idx;
   logic             cmd_empty;
   logic             cmd_full;
   logic             cmd_push;

   // Response FIFO storage and pointers
   logic [WIDTH-1:0] rsp_res_mem  [RSP_DEPTH];
   logic [2:0]       rsp_flag_mem [RSP_DEPTH];
   logic [TAG_W-1:0] rsp_tag_mem  [RSP_DEPTH];
   logic [RA:0]      rsp_wr_ptr;
   logic [RA:0]      rsp_rd_ptr;
   logic [RA-1:0]    rsp_wr_idx;
   logic [RA-1:0]    rsp_rd_idx;
   logic             rsp_empty;
   logic             rsp_pop;

   // Issue control, delay line and credits
   logic             issue;
   logic             capture;
   logic [DL-1:0]    dl_valid;
   logic [TAG_W-1:0] dl_tag [DL];
   logic [RA:0]      credit_cnt;

   assign cmd_wr_idx = cmd_wr_ptr[CA-1:0];
   assign cmd_rd_idx = cmd_rd_ptr[CA-1:0];
   assign cmd_empty  = (cmd_wr_ptr == cmd_rd_ptr);
   assign cmd_full   = (cmd_wr_ptr[CA] != cmd_rd_ptr[CA]) && (cmd_wr_idx == cmd_rd_idx);
   assign cmd_push   = bus.cmd_valid & ~cmd_full;

   assign rsp_wr_idx = rsp_wr_ptr[RA-1:0];
   assign rsp_rd_idx = rsp_rd_ptr[RA-1:0];
   assign rsp_empty  = (rsp_wr_ptr == rsp_rd_ptr);
   assign rsp_pop    = ~rsp_empty & bus.rsp_ready;

   // The credit counter covers both in-flight ops and queued responses, so a
   // capture moving an op from one to the other leaves it unchanged. A pop only
   // frees a credit from the following cycle because the counter is registered.
   assign issue   = ~cmd_empty & (credit_cnt < RSP_DEPTH_C);
   assign capture = dl_valid[DL-1];

   assign bus.cmd_ready  = ~cmd_full;
   assign bus.rsp_valid  = ~rsp_empty;
   assign bus.rsp_result = rsp_empty ? '0 : rsp_res_mem[rsp_rd_idx];
   assign bus.rsp_flags  = rsp_empty ? '0 : rsp_flag_mem[rsp_rd_idx];
   assign bus.rsp_tag    = rsp_empty ? '0 : rsp_tag_mem[rsp_rd_idx];
   assign busy           = ~cmd_empty | (|dl_valid) | ~rsp_empty;

   // Command FIFO payload write; entries need no reset since pointers gate them
   always_ff @(posedge clk) begin
      if (cmd_push) begin
         cmd_op_mem[cmd_wr_idx]  <= bus.cmd_opcode;
         cmd_a_mem[cmd_wr_idx]   <= bus.cmd_a;
         cmd_b_mem[cmd_wr_idx]   <= bus.cmd_b;
         cmd_sh_mem[cmd_wr_idx]  <= bus.cmd_shift;
         cmd_tag_mem[cmd_wr_idx] <= bus.cmd_tag;
      end
   end

   // Command FIFO pointers: push on handshake, pop on issue
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_wr_ptr <= '0;
         cmd_rd_ptr <= '0;
      end else begin
         if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + (CA+1)'(1);
         if (issue)    cmd_rd_ptr <= cmd_rd_ptr + (CA+1)'(1);
      end
   end

   // ALU operand registers load the FIFO head on issue and otherwise hold
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_opcode     <= '0;
         alu_input1     <= '0;
         alu_input2     <= '0;
         alu_shiftValue <= '0;
      end else if (issue) begin
         alu_opcode     <= cmd_op_mem[cmd_rd_idx];
         alu_input1     <= cmd_a_mem[cmd_rd_idx];
         alu_input2     <= cmd_b_mem[cmd_rd_idx];
         alu_shiftValue <= cmd_sh_mem[cmd_rd_idx];
      end
   end

   // Delay line: ALU_LAT+1 stages so an op issued at edge E reaches the output
   // stage after E+ALU_LAT, when its ALU result is stable, and is captured at
   // E+ALU_LAT+1. Idle cycles shift in a zero valid bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         dl_valid <= '0;
         for (int i = 0; i < DL; i++) dl_tag[i] <= '0;
      end else begin
         dl_valid  <= {dl_valid[DL-2:0], issue};
         dl_tag[0] <= cmd_tag_mem[cmd_rd_idx];
         for (int i = 1; i < DL; i++) dl_tag[i] <= dl_tag[i-1];
      end
   end

   // Credit counter: +1 per issue, -1 per response pop
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_cnt <= '0;
      end else begin
         case ({issue, rsp_pop})
            2'b10:   credit_cnt <= credit_cnt + (RA+1)'(1);
            2'b01:   credit_cnt <= credit_cnt - (RA+1)'(1);
            default: credit_cnt <= credit_cnt;
         endcase
      end
   end

   // Response FIFO payload write; flags pass straight through as {carry, zero, sign}
   always_ff @(posedge clk) begin
      if (capture) begin
         rsp_res_mem[rsp_wr_idx]  <= alu_result;
         rsp_flag_mem[rsp_wr_idx] <= {alu_carry, alu_zero, alu_sign};
         rsp_tag_mem[rsp_wr_idx]  <= dl_tag[DL-1];
      end
   end

   // Response FIFO pointers: push on capture, pop on handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_wr_ptr <= '0;
         rsp_rd_ptr <= '0;
      end else begin
         if (capture) rsp_wr_ptr <= rsp_wr_ptr + (RA+1)'(1);
         if (rsp_pop) rsp_rd_ptr <= rsp_rd_ptr + (RA+1)'(1);
      end
   end

`ifdef ALU_DISP_OPCHECK_EN
   // Illegal-opcode marker: any opcode above 7 has bit 3 set. It rides the
   // delay line next to the tag and is stored with the response.
   logic [DL-1:0] dl_err;
   logic          rsp_err_mem [RSP_DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         dl_err <= '0;
      end else begin
         dl_err <= {dl_err[DL-2:0], cmd_op_mem[cmd_rd_idx][3]};
      end
   end

   always_ff @(posedge clk) begin
      if (capture) rsp_err_mem[rsp_wr_idx] <= dl_err[DL-1];
   end

   assign bus.rsp_err = ~rsp_empty & rsp_err_mem[rsp_rd_idx];
`else
   assign bus.rsp_err = 1'b0;
`endif

endmodule
